neureka_evt_unit: RTL

- Downstream of the accelerator top level: consumes its per-core event vector `evt_o` and its `busy_o` flag.
- Turns single-cycle event pulses into sticky per-core pending bits and registered interrupt lines.
- Counts completed jobs and runs a job-timeout watchdog on the busy window.
- Sits between the accelerator and the cluster event unit / core interrupt inputs.

---
 rtl/neureka_evt_unit_if.sv | 41 ++++
 rtl/neureka_evt_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/neureka_evt_unit_if.sv
// rtl/neureka_evt_unit_if.sv - event/busy inputs and interrupt-side outputs of neureka_evt_unit (NEUREKA_EVT_PERF_EN adds busy_cycles_o)
interface neureka_evt_unit_if #(
  parameter int N_CORES       = 8,
  parameter int REGFILE_N_EVT = 2,
  parameter int CNT_W         = 16,
  parameter int TO_W          = 24
);
  logic [N_CORES*REGFILE_N_EVT-1:0] evt_i;
  logic                             busy_i;
  logic [N_CORES-1:0]               ack_i;
  logic [TO_W-1:0]                  timeout_cfg_i;
  logic [N_CORES*REGFILE_N_EVT-1:0] pending_o;
  logic [N_CORES-1:0]               overrun_o;
  logic [N_CORES-1:0]               irq_o;
  logic [CNT_W-1:0]                 job_cnt_o;
  logic                             timeout_o;
  logic [1:0]                       wd_state_o;
`ifdef NEUREKA_EVT_PERF_EN
  logic [31:0]                      busy_cycles_o;

  modport master (
    output evt_i, busy_i, ack_i, timeout_cfg_i,
    input  pending_o, overrun_o, irq_o, job_cnt_o, timeout_o, wd_state_o, busy_cycles_o
  );

  modport slave (
    input  evt_i, busy_i, ack_i, timeout_cfg_i,
    output pending_o, overrun_o, irq_o, job_cnt_o, timeout_o, wd_state_o, busy_cycles_o
  );
`else
  modport master (
    output evt_i, busy_i, ack_i, timeout_cfg_i,
    input  pending_o, overrun_o, irq_o, job_cnt_o, timeout_o, wd_state_o
  );

  modport slave (
    input  evt_i, busy_i, ack_i, timeout_cfg_i,
    output pending_o, overrun_o, irq_o, job_cnt_o, timeout_o, wd_state_o
  );
`endif
endinterface

// File: rtl/neureka_evt_unit.sv
// rtl/neureka_evt_unit.sv - sticky per-core events, registered irqs, job counter and busy watchdog (NEUREKA_EVT_PERF_EN adds busy-cycle counter)
module neureka_evt_unit #(
  parameter int N_CORES       = 8,
  parameter int REGFILE_N_EVT = 2,
  parameter int CNT_W         = 16,
  parameter int TO_W          = 24
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  neureka_evt_unit_if.slave bus
);

  localparam int N_EVT = N_CORES * REGFILE_N_EVT;

  typedef enum logic [1:0] {
    WD_IDLE    = 2'd0,
    WD_RUN     = 2'd1,
    WD_TIMEOUT = 2'd2
  } wd_state_e;

  logic [N_EVT-1:0]   pending_q, pending_d;
  logic [N_CORES-1:0] overrun_q, overrun_d;
  logic [N_CORES-1:0] irq_q, irq_d;
  logic               busy_q;
  logic               job_done;
  logic [CNT_W-1:0]   job_cnt_q, job_cnt_d;
  wd_state_e          wd_state_q, wd_state_d;
  logic [TO_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic [TO_W-1:0]    wd_limit;

  // Pending bits: an event in the same cycle as an ack wins, so nothing is lost.
  // Overrun: set when an event hits an already pending, un-acked bit; ack clears it.
  // Irq: one cycle behind pending, so it reflects the registered pending state.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    irq_d     = irq_q;
    for (int c = 0; c < N_CORES; c++) begin
      pending_d[c*REGFILE_N_EVT +: REGFILE_N_EVT] =
          bus.evt_i[c*REGFILE_N_EVT +: REGFILE_N_EVT] |
          (pending_q[c*REGFILE_N_EVT +: REGFILE_N_EVT] & {REGFILE_N_EVT{~bus.ack_i[c]}});
      if (bus.ack_i[c]) begin
        overrun_d[c] = 1'b0;
      end else if (|(bus.evt_i[c*REGFILE_N_EVT +: REGFILE_N_EVT] &
                     pending_q[c*REGFILE_N_EVT +: REGFILE_N_EVT])) begin
        overrun_d[c] = 1'b1;
      end
      irq_d[c] = |pending_q[c*REGFILE_N_EVT +: REGFILE_N_EVT];
    end
  end

  // A job completes on each busy falling edge; the count sticks at all-ones.
  assign job_done  = busy_q & ~bus.busy_i;
  assign job_cnt_d = (job_done && (job_cnt_q != {CNT_W{1'b1}})) ? job_cnt_q + CNT_W'(1) : job_cnt_q;

  // The limit is compared live; a zero limit never reaches RUN so its wrap is harmless.
  assign wd_limit = bus.timeout_cfg_i - TO_W'(1);

  // Watchdog next-state: RUN counts busy cycles, TIMEOUT holds until clear/reset.
  always_comb begin
    wd_state_d = wd_state_q;
    wd_cnt_d   = wd_cnt_q;
    unique case (wd_state_q)
      WD_IDLE: begin
        if (bus.busy_i && (bus.timeout_cfg_i != '0)) begin
          wd_state_d = WD_RUN;
          wd_cnt_d   = '0;
        end
      end
      WD_RUN: begin
        if (!bus.busy_i) begin
          wd_state_d = WD_IDLE;
        end else if (wd_cnt_q == wd_limit) begin
          wd_state_d = WD_TIMEOUT;
        end else begin
          wd_cnt_d = wd_cnt_q + TO_W'(1);
        end
      end
      WD_TIMEOUT: begin
        wd_state_d = WD_TIMEOUT;
      end
      default: begin
        wd_state_d = WD_IDLE;
      end
    endcase
  end

  // State registers; clear_i behaves like a synchronous reset and beats every other input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q  <= '0;
      overrun_q  <= '0;
      irq_q      <= '0;
      busy_q     <= 1'b0;
      job_cnt_q  <= '0;
      wd_state_q <= WD_IDLE;
      wd_cnt_q   <= '0;
    end else if (clear_i) begin
      pending_q  <= '0;
      overrun_q  <= '0;
      irq_q      <= '0;
      busy_q     <= 1'b0;
      job_cnt_q  <= '0;
      wd_state_q <= WD_IDLE;
      wd_cnt_q   <= '0;
    end else begin
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      irq_q      <= irq_d;
      busy_q     <= bus.busy_i;
      job_cnt_q  <= job_cnt_d;
      wd_state_q <= wd_state_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end

  assign bus.pending_o  = pending_q;
  assign bus.overrun_o  = overrun_q;
  assign bus.irq_o      = irq_q;
  assign bus.job_cnt_o  = job_cnt_q;
  assign bus.timeout_o  = (wd_state_q == WD_TIMEOUT);
  assign bus.wd_state_o = wd_state_q;

`ifdef NEUREKA_EVT_PERF_EN
  logic [31:0] busy_cycles_q;

  // Saturating count of cycles spent busy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_cycles_q <= '0;
    end else if (clear_i) begin
      busy_cycles_q <= '0;
    end else if (bus.busy_i && (busy_cycles_q != 32'hFFFF_FFFF)) begin
      busy_cycles_q <= busy_cycles_q + 32'd1;
    end
  end

  assign bus.busy_cycles_o = busy_cycles_q;
`endif

endmodule
